// File: rtl/mac_sequencer.sv
// Operand sequencer and psum collector for a single 3-cycle kernel_mac lane:
// streams weight/iact pairs into the MAC and folds its output back as the next psum.
module mac_sequencer #(
  parameter int OP_WIDTH    = 8,
  parameter int ACC_WIDTH   = 20,
  parameter int KMAX        = 16,
  parameter int MAC_LATENCY = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(KMAX+1)-1:0]  cfg_k,
  input  logic [ACC_WIDTH-1:0]       bias,
  output logic                       busy,
  input  logic                       w_wr_en,
  input  logic [$clog2(KMAX)-1:0]    w_wr_addr,
  input  logic [OP_WIDTH-1:0]        w_wr_data,
  input  logic                       iact_valid,
  output logic                       iact_ready,
  input  logic [OP_WIDTH-1:0]        iact_data,
  output logic [OP_WIDTH-1:0]        mac_weights,
  output logic [OP_WIDTH-1:0]        mac_iacts,
  output logic [ACC_WIDTH-1:0]       mac_psums,
  input  logic [ACC_WIDTH-1:0]       mac_outputs,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_WIDTH-1:0]       out_data,
  output logic [1:0]                 dbg_state
);

  localparam int KW = $clog2(KMAX + 1);
  localparam int AW = $clog2(KMAX);
  localparam logic [1:0]    DRAIN_LAST = 2'(MAC_LATENCY - 1);
  localparam logic [KW-1:0] K_MAX      = KW'(KMAX);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [KW-1:0]        r_idx;
  logic [KW-1:0]        r_k;
  logic [KW-1:0]        w_idx_inc;
  logic [ACC_WIDTH-1:0] r_bias;
  logic [1:0]           r_drain_cnt;
  logic                 r_first;
  logic                 r_slot_p1, r_slot_p2;
  logic                 r_first_p1, r_first_p2;
  logic [OP_WIDTH-1:0]  r_wmem [KMAX];
  logic                 w_start_ok;
  logic                 w_hs;

  // Both streams use strict valid/ready: a transfer happens on a rising edge
  // where valid and ready are both high; ready never depends on a future cycle.

  assign w_idx_inc = r_idx + KW'(1);
  assign dbg_state = r_state;

  always_comb begin
    w_next      = r_state;
    busy        = 1'b1;
    iact_ready  = 1'b0;
    w_hs        = 1'b0;
    w_start_ok  = 1'b0;
    mac_weights = '0;
    mac_iacts   = '0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start && (cfg_k != '0) && (cfg_k <= K_MAX)) begin
          w_start_ok = 1'b1;
          w_next     = S_RUN;
        end
      end
      S_RUN: begin
        iact_ready = (r_idx < r_k);
        w_hs       = iact_ready && iact_valid;
        if (w_hs) begin
          mac_weights = r_wmem[r_idx[AW-1:0]];
          mac_iacts   = iact_data;
          if (w_idx_inc == r_k) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == DRAIN_LAST) w_next = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // The MAC consumes a slot's psum two cycles after its operands, so track
  // which cycles carry a slot and which slot is the first one of the job.
  assign mac_psums = r_slot_p2 ? (r_first_p2 ? r_bias : mac_outputs) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_k         <= '0;
      r_bias      <= '0;
      r_drain_cnt <= '0;
      r_first     <= 1'b0;
      r_slot_p1   <= 1'b0;
      r_slot_p2   <= 1'b0;
      r_first_p1  <= 1'b0;
      r_first_p2  <= 1'b0;
      out_data    <= '0;
    end else begin
      r_state    <= w_next;
      r_first    <= w_start_ok;
      r_slot_p1  <= (r_state == S_RUN);
      r_slot_p2  <= r_slot_p1;
      r_first_p1 <= r_first;
      r_first_p2 <= r_first_p1;
      if (w_start_ok) begin
        r_k         <= cfg_k;
        r_bias      <= bias;
        r_idx       <= '0;
        r_drain_cnt <= '0;
      end
      if (w_hs) r_idx <= w_idx_inc;
      if (r_state == S_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 2'd1;
        if (r_drain_cnt == DRAIN_LAST) out_data <= mac_outputs;
      end
    end
  end

  // Scratchpad has no reset; writes land only while idle.
  always_ff @(posedge clk) begin
    if (w_wr_en && (r_state == S_IDLE)) r_wmem[w_wr_addr] <= w_wr_data;
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: behavioural kernel_mac stand-in, transaction-level
// reference model with per-cycle compare, directed pins and randomized jobs.
module tb_mac_sequencer;
  localparam int OPW  = 8;
  localparam int ACCW = 20;
  localparam int KMAX = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            start;
  logic [4:0]      cfg_k;
  logic [ACCW-1:0] bias;
  logic            busy;
  logic            w_wr_en;
  logic [3:0]      w_wr_addr;
  logic [OPW-1:0]  w_wr_data;
  logic            iact_valid;
  logic            iact_ready;
  logic [OPW-1:0]  iact_data;
  logic [OPW-1:0]  mac_weights;
  logic [OPW-1:0]  mac_iacts;
  logic [ACCW-1:0] mac_psums;
  logic [ACCW-1:0] mac_outputs;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] out_data;
  logic [1:0]      dbg_state;

  mac_sequencer #(.OP_WIDTH(OPW), .ACC_WIDTH(ACCW), .KMAX(KMAX), .MAC_LATENCY(3)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .bias(bias), .busy(busy),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .iact_valid(iact_valid), .iact_ready(iact_ready), .iact_data(iact_data),
    .mac_weights(mac_weights), .mac_iacts(mac_iacts), .mac_psums(mac_psums),
    .mac_outputs(mac_outputs), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .dbg_state(dbg_state)
  );

  function automatic logic [ACCW-1:0] prod(input logic [OPW-1:0] w, input logic [OPW-1:0] x);
    logic signed [ACCW-1:0] a, b;
    a = {{(ACCW-OPW){w[OPW-1]}}, w};
    b = {{(ACCW-OPW){x[OPW-1]}}, x};
    return ACCW'(a * b);
  endfunction

  // kernel_mac stand-in: product, delay, then add the psum present 2 cycles after issue
  logic [ACCW-1:0] mac_p1 = '0, mac_p2 = '0, mac_out_r = '0;
  always @(posedge clk) begin
    mac_p1    <= prod(mac_weights, mac_iacts);
    mac_p2    <= mac_p1;
    mac_out_r <= mac_p2 + mac_psums;
  end
  assign mac_outputs = mac_out_r;

  // ---------------- scoreboard bookkeeping ----------------
  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [OPW-1:0]  wm [KMAX];
  logic [ACCW-1:0] exp_q [$];
  bit              m_on = 1'b0;
  int              m_s, m_k, m_hs, m_hsk;
  logic [ACCW-1:0] m_bias, m_sum;
  logic [ACCW-1:0] m_last_model, last_dut_data;
  int              dut_lat;
  bit              prev_dut_ov = 1'b0;

  initial for (int i = 0; i < KMAX; i++) wm[i] = '0;

  always @(negedge clk) begin
    bit              e_ready, hs, e_ov;
    logic [ACCW-1:0] e_psum;
    if (rst) begin
      m_on = 1'b0;
      exp_q.delete();
      prev_dut_ov = 1'b0;
    end else begin
      e_ready = m_on && (cyc > m_s) && (m_hs < m_k);
      hs      = e_ready && iact_valid;
      e_ov    = m_on && (m_hsk >= 0) && (cyc >= m_hsk + 4);
      if (!m_on)                                                      e_psum = '0;
      else if (cyc == m_s + 3)                                        e_psum = m_bias;
      else if (cyc > m_s + 3 && (m_hsk < 0 || cyc <= m_hsk + 2))      e_psum = mac_outputs;
      else                                                            e_psum = '0;

      chk("busy", 32'(busy), 32'(m_on));
      chk("iact_ready", 32'(iact_ready), 32'(e_ready));
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      chk("mac_iacts", 32'(mac_iacts), hs ? 32'(iact_data) : 32'd0);
      chk("mac_weights", 32'(mac_weights), hs ? 32'(wm[m_hs]) : 32'd0);
      chk("mac_psums", 32'(mac_psums), 32'(e_psum));
      if (e_ov) begin
        if (exp_q.size() > 0) chk("out_data", 32'(out_data), 32'(exp_q[0]));
        else                  chk("exp_q_empty", 32'(exp_q.size()), 32'd1);
      end

      if (out_valid && !prev_dut_ov) dut_lat = cyc - m_s;
      prev_dut_ov = out_valid;
      if (out_valid && out_ready) last_dut_data = out_data;

      if (!m_on && w_wr_en) wm[w_wr_addr] = w_wr_data;
      if (hs) begin
        m_sum = m_sum + prod(wm[m_hs], iact_data);
        m_hs++;
        if (m_hs == m_k) begin
          m_hsk = cyc;
          exp_q.push_back(m_sum);
        end
      end
      if (e_ov && out_ready) begin
        if (exp_q.size() > 0) m_last_model = exp_q.pop_front();
        m_on = 1'b0;
      end else if (!m_on && start && cfg_k >= 5'd1 && cfg_k <= 5'd16) begin
        m_on = 1'b1; m_s = cyc; m_k = int'(cfg_k); m_bias = bias; m_sum = bias;
        m_hs = 0; m_hsk = -1;
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  logic [OPW-1:0] x_arr [KMAX];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; iact_valid = 1'b0; out_ready = 1'b0; w_wr_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_iact_ready"}, 32'(iact_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_mac_w"}, 32'(mac_weights), 32'd0);
    chk({tag, "_mac_x"}, 32'(mac_iacts), 32'd0);
    chk({tag, "_mac_p"}, 32'(mac_psums), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic write_w(input int a, input logic [OPW-1:0] d);
    w_wr_en = 1'b1; w_wr_addr = 4'(a); w_wr_data = d;
    tick();
    w_wr_en = 1'b0;
  endtask

  // bub_at < 0: random bubbles; otherwise bub_n bubbles before term bub_at
  task automatic run_job(input int k, input logic [ACCW-1:0] b, input int bub_at,
                         input int bub_n, input int bp, input bit noise);
    int t, nb;
    start = 1'b1; cfg_k = 5'(k); bias = b;
    tick();
    start = 1'b0; cfg_k = 5'($urandom_range(0, 31)); bias = ACCW'($urandom);
    for (int i = 0; i < k; i++) begin
      if (bub_at < 0) nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      else            nb = (i == bub_at) ? bub_n : 0;
      iact_valid = 1'b0;
      repeat (nb) begin iact_data = OPW'($urandom); tick(); end
      iact_valid = 1'b1; iact_data = x_arr[i];
      t = 0;
      do begin @(negedge clk); t++; end while (!iact_ready && t < 40);
      if (!iact_ready) begin
        chk("hs_timeout", 32'(iact_ready), 32'd1);
        do_reset();
        return;
      end
      @(posedge clk); #1;
    end
    iact_valid = 1'b0;
    out_ready = (bp == 0);
    t = 0;
    do begin @(negedge clk); t++; end while (!out_valid && t < 40);
    if (!out_valid) begin
      chk("out_timeout", 32'(out_valid), 32'd1);
      do_reset();
      return;
    end
    @(posedge clk); #1;
    if (bp > 0) begin
      repeat (bp - 1) begin
        if (noise) begin
          start = 1'b1; cfg_k = 5'd3;
          w_wr_en = 1'b1; w_wr_addr = 4'($urandom); w_wr_data = OPW'($urandom);
        end
        tick();
      end
      start = 1'b0; w_wr_en = 1'b0; out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic pin(input string nm, input int got, input int lit);
    chk(nm, 32'(got), 32'(lit));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    start = 0; cfg_k = 0; bias = 0; w_wr_en = 0; w_wr_addr = 0; w_wr_data = 0;
    iact_valid = 0; iact_data = 0; out_ready = 0; rst = 1;
    tick();
    do_reset();
    check_idle_zero("reset");

    for (int i = 0; i < KMAX; i++) write_w(i, (i < 4) ? OPW'(i + 1) : OPW'($urandom));
    for (int i = 0; i < 4; i++) x_arr[i] = OPW'(i + 5);

    run_job(4, 20'd10, 99, 0, 0, 1'b0);
    pin("basic_model", int'(m_last_model), 80);
    pin("basic_dut", int'(last_dut_data), 80);
    pin("basic_lat", dut_lat, 8);

    run_job(4, 20'd10, 2, 2, 0, 1'b0);
    pin("bubble_dut", int'(last_dut_data), 80);
    pin("bubble_lat", dut_lat, 10);

    run_job(4, 20'd10, 99, 0, 5, 1'b1);
    pin("bp_dut", int'(last_dut_data), 80);
    pin("bp_lat", dut_lat, 8);
    run_job(4, 20'd10, 99, 0, 0, 1'b0);
    pin("after_bp_dut", int'(last_dut_data), 80);

    write_w(0, 8'hFF); x_arr[0] = 8'h80;
    run_job(1, 20'hFFFFB, 99, 0, 0, 1'b0);
    pin("signed_model", int'(m_last_model), 123);
    pin("signed_dut", int'(last_dut_data), 123);

    for (int i = 0; i < KMAX; i++) begin write_w(i, 8'd127); x_arr[i] = 8'd127; end
    run_job(16, 20'h7FFFF, 99, 0, 1, 1'b0);
    pin("wrap_model", int'(m_last_model), 32'hBF00F);
    pin("wrap_dut", int'(last_dut_data), 32'hBF00F);
    pin("wrap_lat", dut_lat, 20);

    // reset in the middle of RUN after two handshakes
    start = 1'b1; cfg_k = 5'd4; bias = 20'd7;
    tick();
    start = 1'b0; iact_valid = 1'b1; iact_data = 8'd5;
    tick(); tick();
    iact_valid = 1'b0;
    do_reset();
    check_idle_zero("midrun");
    repeat (8) tick();
    write_w(0, 8'd3); x_arr[0] = 8'd3;
    run_job(1, 20'd0, 99, 0, 0, 1'b0);
    pin("fresh_model", int'(m_last_model), 9);
    pin("fresh_dut", int'(last_dut_data), 9);

    for (int j = 0; j < 30; j++) begin
      int k;
      if ($urandom_range(0, 2) == 0)
        for (int i = 0; i < KMAX; i++) write_w(i, OPW'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        start = 1'b1;
        cfg_k = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(17, 31));
        tick();
        start = 1'b0;
        tick();
      end
      k = $urandom_range(1, KMAX);
      for (int i = 0; i < KMAX; i++) x_arr[i] = OPW'($urandom);
      run_job(k, ACCW'($urandom), -1, 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      tick();
    end

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Operand sequencer and partial-sum collector for one `kernel_mac` lane (LANES=1, 3-cycle latency). It does three things:
- holds a kernel's weights in a local scratchpad;
- accepts a valid/ready iact stream and issues one weight/iact pair to the MAC every cycle;
- loops the MAC output back as the next psum, so a K-term dot product plus bias accumulates with no stalls.

The finished sum is returned on a valid/ready result port. The block sits between the PE's iact/weight feeders and the psum output NoC.

## Interface
- `OP_WIDTH`, 8, operand width (signed two's complement)
- `ACC_WIDTH`, 20, accumulator/psum width
- `KMAX`, 16, weight scratchpad depth and maximum terms per dot product
- `MAC_LATENCY`, 3, MAC issue-to-output latency. Only 3 is supported.
- `clk`  in  1  single clock; all state on posedge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a dot product; honoured only in IDLE
- `cfg_k`  in  $clog2(KMAX+1)  term count, sampled with `start`
- `bias`  in  ACC_WIDTH  initial psum, sampled with `start`
- `busy`  out  1  high in every state except IDLE
- `w_wr_en`  in  1  weight scratchpad write strobe
- `w_wr_addr`  in  $clog2(KMAX)  write address
- `w_wr_data`  in  OP_WIDTH  write data
- `iact_valid`  in  1  iact stream valid
- `iact_ready`  out  1  iact stream ready
- `iact_data`  in  OP_WIDTH  iact value
- `mac_weights`  out  OP_WIDTH  to MAC `weights`
- `mac_iacts`  out  OP_WIDTH  to MAC `iacts`
- `mac_psums`  out  ACC_WIDTH  to MAC `psums`
- `mac_outputs`  in  ACC_WIDTH  from MAC `outputs`
- `out_valid`  out  1  result valid
- `out_ready`  in  1  result consumer ready
- `out_data`  out  ACC_WIDTH  result

## Operation
- **States:** IDLE, RUN, DRAIN, OUT.
- **IDLE -> RUN:** on `start` with 1 <= `cfg_k` <= KMAX.
  - Latch k and bias; clear term index idx and slot counter.
  - `start` with `cfg_k`=0 or `cfg_k`>KMAX is ignored; the block stays in IDLE.
- **RUN:**
  - `iact_ready`=1 while idx<k.
  - Handshake cycle: drive `mac_iacts`=`iact_data`, `mac_weights`=wmem[idx], then idx++.
  - Any other RUN cycle issues a bubble: both operands 0.
  - When the k-th handshake completes, go to DRAIN.
- **DRAIN:** MAC_LATENCY cycles with operands 0, waiting for the final term to exit the MAC.
  - In the last DRAIN cycle, register `mac_outputs` into `out_data`, then go to OUT.
- **OUT:** `out_valid`=1.
  - `out_data` and `out_valid` hold until `out_ready`=1; go to IDLE on the next edge.
- **Psum alignment:** the MAC adds the psum present 2 cycles after the operands.
  - For the first RUN slot, `mac_psums`=`bias` two cycles later.
  - For every later slot (real or bubble), `mac_psums`=`mac_outputs`, combinational feedback.
  - Outside these alignment cycles, `mac_psums`=0.
  - Bubbles add zero, so the sum is unaffected.
- **Arithmetic:** signed OP_WIDTH x OP_WIDTH products plus signed psums; the result wraps modulo 2^ACC_WIDTH with no saturation.
- **Weight writes:** a `w_wr_en` write takes effect only in IDLE; it is ignored while `busy`. The scratchpad is not reset.
- **`start` while busy:** ignored.
- **MAC operands:** `mac_weights` and `mac_iacts` are 0 in IDLE, DRAIN and OUT.

## Timing
- **Reset:** state=IDLE and idx=0. `busy`, `iact_ready`, `out_valid`, `out_data`, `mac_weights`, `mac_iacts` and `mac_psums` are all 0 from the cycle after `rst` is sampled.
- **Reset mid-operation:** RUN/DRAIN/OUT aborts; in-flight MAC results are discarded and `out_valid` is never raised for the aborted job.
- **Reference points:** `start` accepted in cycle S; RUN begins in cycle S+1.
- **No bubbles:** terms issue in S+1..S+k; `out_valid` rises in cycle S+k+4.
- **With bubbles:** each bubble cycle adds 1 cycle of latency.
- **Throughput:** 1 term/cycle; minimum job-to-job gap is OUT -> IDLE -> `start`.
- **Back-pressure:** `iact_ready` is 0 outside RUN; `out_data` is stable while `out_valid` && !`out_ready`.

## Test plan
- **Basic dot product:** weights 1,2,3,4; `cfg_k`=4; bias=10; iacts 5,6,7,8 back-to-back -> `out_data`=80 (0x00050), `out_valid` in S+8.
- **Signed:** w=0xFF, x=0x80, k=1, bias=-5 -> `out_data`=123.
- **Bubbles:** as the basic test, with `iact_valid` low for 2 cycles between terms 2 and 3 -> `out_data`=80, `out_valid` in S+10.
- **Back-pressure:** `out_ready` low 5 cycles, with `start` pulsed and `w_wr_en` writes during OUT -> `out_data` held, `start` and writes ignored, `iact_ready`=0; result accepted on the first `out_ready`.
- **Wrap-around:** k=16, all w=127 and x=127, bias=0x7FFFF -> `out_data`=0xBF00F.
- **Reset mid-RUN:** after 2 handshakes, assert `rst` -> IDLE, no `out_valid`. A fresh run with k=1, w=3, x=3, bias=0 -> 9 (no stale psum).
